// File: rtl/mbit_sel_pkg.sv
// Shared types and default parameters for the mbit_sel_pipe AND-OR selector.
package mbit_sel_pkg;

  localparam int unsigned DefWidth    = 130;
  localparam int unsigned DefChannels = 2;
  localparam int unsigned DefCntW     = 8;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } buf_state_e;

endpackage

// File: rtl/mbit_andor_merge.sv
// Combinational replicate-and-mask AND-OR merge of CHANNELS words under a select vector.
module mbit_andor_merge
  import mbit_sel_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned CHANNELS = DefChannels
) (
  input  logic [CHANNELS-1:0]       sel_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]          word_o
);

  // Multi-hot selects OR the chosen channels together; all-zero select yields zero.
  always_comb begin
    word_o = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      word_o = word_o | ({WIDTH{sel_i[i]}} & data_i[i*WIDTH +: WIDTH]);
    end
  end

endmodule

// File: rtl/mbit_sel_pipe.sv
// Registered AND-OR multi-bit selector with a 2-entry valid/ready output buffer.
// Optional one-hot checking (out_err flag, err_count) under MBIT_SEL_ONEHOT_CHK_EN.
module mbit_sel_pipe
  import mbit_sel_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned CHANNELS = DefChannels,
  parameter int unsigned CNT_W    = DefCntW
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS-1:0]       in_sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_err,
  output logic [CNT_W-1:0]          err_count
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [WIDTH-1:0] merged;
  logic             push, pop;
  logic             head_ld_new, head_ld_tail, tail_ld;

  mbit_andor_merge #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_merge (
    .sel_i  (in_sel),
    .data_i (in_data),
    .word_o (merged)
  );

  assign in_ready  = !reset && (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = head_q;

  always_comb begin
    state_d      = state_q;
    head_ld_new  = 1'b0;
    head_ld_tail = 1'b0;
    tail_ld      = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          state_d     = StOne;
          head_ld_new = 1'b1;
        end
      end
      StOne: begin
        // Push with pop replaces the head in place, occupancy unchanged.
        if (push && pop) begin
          head_ld_new = 1'b1;
        end else if (push) begin
          state_d = StFull;
          tail_ld = 1'b1;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          state_d      = StOne;
          head_ld_tail = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (head_ld_new) begin
      head_d = merged;
    end else if (head_ld_tail) begin
      head_d = tail_q;
    end
    if (tail_ld) begin
      tail_d = merged;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef MBIT_SEL_ONEHOT_CHK_EN
  logic             multi_hot;
  logic             head_err_q, head_err_d;
  logic             tail_err_q, tail_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // x & (x - 1) is non-zero exactly when more than one bit is set.
  assign multi_hot = |(in_sel & (in_sel - CHANNELS'(1)));

  always_comb begin
    head_err_d = head_err_q;
    tail_err_d = tail_err_q;
    cnt_d      = cnt_q;
    if (head_ld_new) begin
      head_err_d = multi_hot;
    end else if (head_ld_tail) begin
      head_err_d = tail_err_q;
    end
    if (tail_ld) begin
      tail_err_d = multi_hot;
    end
    if (push && multi_hot && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_err_q <= 1'b0;
      tail_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      head_err_q <= head_err_d;
      tail_err_q <= tail_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_err   = head_err_q;
  assign err_count = cnt_q;
`else
  assign out_err   = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_mbit_sel_pipe.sv
// Self-checking bench for mbit_sel_pipe: queue scoreboard fed by a reference buffer model.
module tb_mbit_sel_pipe;

  localparam int unsigned W  = 130;
  localparam int unsigned C  = 2;
  localparam int unsigned CW = 8;

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [C-1:0]  in_sel    = '0;
  logic [W-1:0]  ch0       = '0;
  logic [W-1:0]  ch1       = '0;
  logic          in_ready, out_valid, out_err;
  logic [W-1:0]  out_data;
  logic [C*W-1:0] in_data;
  logic [CW-1:0] err_count;

  assign in_data = {ch1, ch0};

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } ent_t;

  ent_t        exp_q[$];
  int unsigned exp_cnt = 0;
  int unsigned n_chk   = 0;
  int unsigned n_pass  = 0;

  localparam logic [W-1:0] A0  = 130'h0_0123456789abcdef_0123456789abcdef;
  localparam logic [W-1:0] A1  = 130'h3_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF;
  localparam logic [W-1:0] M0  = 130'h1_0000000000000000_00000000000000F0;
  localparam logic [W-1:0] M1  = 130'h0_0000000000000000_000000000000000F;
  localparam logic [W-1:0] MOR = 130'h1_0000000000000000_00000000000000FF;

  mbit_sel_pipe #(
    .WIDTH    (W),
    .CHANNELS (C),
    .CNT_W    (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  function automatic ent_t model(logic [C-1:0] sel, logic [W-1:0] a, logic [W-1:0] b);
    ent_t e;
    e.data = (sel[0] ? a : '0) | (sel[1] ? b : '0);
`ifdef MBIT_SEL_ONEHOT_CHK_EN
    e.err = sel[0] && sel[1];
`else
    e.err = 1'b0;
`endif
    return e;
  endfunction

  // One clock: updates the reference buffer and scoreboard, returns 1 time unit after the edge.
  task automatic step();
    bit   do_pop, do_push;
    ent_t e;
    do_pop  = (exp_q.size() != 0) && out_ready;
    do_push = in_valid && (exp_q.size() < 2);
    e       = model(in_sel, ch0, ch1);
    @(posedge clock);
    if (reset) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(e);
        if (e.err && exp_cnt < (1 << CW) - 1) exp_cnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready);
    else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_chk++; if (out_data !== '0) $display("FAIL rst_out_data: got %h want 0", out_data);
    else n_pass++;
    n_chk++; if (out_err !== 1'b0) $display("FAIL rst_out_err: got %b want 0", out_err);
    else n_pass++;
    n_chk++; if (err_count !== '0) $display("FAIL rst_err_count: got %0d want 0", err_count);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 2'b01; ch0 = A0; ch1 = A1;
    step();
    n_chk++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid);
    else n_pass++;
    n_chk++; if (out_data !== exp_q[0].data)
      $display("FAIL basic_data: got %h want %h", out_data, exp_q[0].data);
    else n_pass++;
    n_chk++; if (out_data !== A0) $display("FAIL basic_ch0: got %h want %h", out_data, A0);
    else n_pass++;
    n_chk++; if (out_err !== exp_q[0].err)
      $display("FAIL basic_err: got %b want %b", out_err, exp_q[0].err);
    else n_pass++;
    in_sel = 2'b00;
    step();
    in_valid = 1'b0;
    n_chk++; if (out_data !== exp_q[0].data || exp_q[0].data !== '0)
      $display("FAIL zero_sel_data: got %h want %h", out_data, exp_q[0].data);
    else n_pass++;
    n_chk++; if (out_err !== 1'b0) $display("FAIL zero_sel_err: got %b want 0", out_err);
    else n_pass++;
    n_chk++; if (err_count !== CW'(exp_cnt))
      $display("FAIL zero_sel_cnt: got %0d want %0d", err_count, exp_cnt);
    else n_pass++;
    step();
  endtask

  task automatic test_multi_hot();
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 2'b11; ch0 = M0; ch1 = M1;
    step();
    n_chk++; if (out_data !== MOR) $display("FAIL mh_data: got %h want %h", out_data, MOR);
    else n_pass++;
    n_chk++; if (out_err !== exp_q[0].err)
      $display("FAIL mh_err: got %b want %b", out_err, exp_q[0].err);
    else n_pass++;
    n_chk++; if (err_count !== CW'(exp_cnt))
      $display("FAIL mh_cnt: got %0d want %0d", err_count, exp_cnt);
    else n_pass++;
    for (int i = 0; i < 300; i++) step();
    n_chk++; if (err_count !== CW'(exp_cnt))
      $display("FAIL mh_sat: got %0d want %0d", err_count, exp_cnt);
    else n_pass++;
`ifdef MBIT_SEL_ONEHOT_CHK_EN
    n_chk++; if (err_count !== 8'd255) $display("FAIL mh_sat255: got %0d want 255", err_count);
    else n_pass++;
`endif
    step();
    in_valid = 1'b0;
    n_chk++; if (err_count !== CW'(exp_cnt))
      $display("FAIL mh_hold: got %0d want %0d", err_count, exp_cnt);
    else n_pass++;
    step();
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] a_data;
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'b01; ch0 = 130'h2_1111_2222_3333_4444; ch1 = 130'h5555;
    step();
    in_sel = 2'b10;
    step();
    in_valid = 1'b0;
    a_data = exp_q[0].data;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", in_ready);
    else n_pass++;
    n_chk++; if (out_data !== a_data) $display("FAIL bp_head_a: got %h want %h", out_data, a_data);
    else n_pass++;
    step();
    n_chk++; if (out_data !== a_data || out_valid !== 1'b1)
      $display("FAIL bp_stall_hold: got %h want %h", out_data, a_data);
    else n_pass++;
    out_ready = 1'b1;
    step();
    n_chk++; if (out_data !== exp_q[0].data || out_data !== 130'h5555)
      $display("FAIL bp_head_b: got %h want %h", out_data, exp_q[0].data);
    else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", in_ready);
    else n_pass++;
    step();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'b01; ch0 = 130'hAAAA; ch1 = 130'hCCCC;
    step();
    in_sel = 2'b10; out_ready = 1'b1;
    n_chk++; if (out_data !== 130'hAAAA) $display("FAIL sim_head_a: got %h want aaaa", out_data);
    else n_pass++;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    n_chk++; if (out_data !== exp_q[0].data || out_data !== 130'hCCCC)
      $display("FAIL sim_head_c: got %h want %h", out_data, exp_q[0].data);
    else n_pass++;
    n_chk++; if (out_valid !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL sim_count_one: got valid %b ready %b want 1 1", out_valid, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'b11; ch0 = 130'h10; ch1 = 130'h01;
    step();
    step();
    n_chk++; if (in_ready !== 1'b0) $display("FAIL mr_full: got %b want 0", in_ready);
    else n_pass++;
    reset = 1'b1; in_sel = 2'b01; ch0 = 130'hDEAD;
    #1;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL mr_ready_in_rst: got %b want 0", in_ready);
    else n_pass++;
    step();
    reset = 1'b0; in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL mr_valid: got %b want 0", out_valid);
    else n_pass++;
    n_chk++; if (out_data !== '0) $display("FAIL mr_data: got %h want 0", out_data);
    else n_pass++;
    n_chk++; if (err_count !== '0 || out_err !== 1'b0)
      $display("FAIL mr_err: got cnt %0d err %b want 0 0", err_count, out_err);
    else n_pass++;
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL mr_ready_after: got %b want 1", in_ready);
    else n_pass++;
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 2'b10; ch1 = 130'hBEEF;
    step();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_data !== exp_q[0].data)
      $display("FAIL mr_first_word: got %b %h want 1 %h", out_valid, out_data, exp_q[0].data);
    else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_hot();
    test_back_pressure();
    test_simultaneous();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
